// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts one byte plus odd parity and stop on device clock falls, then checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_STOP, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ecnt_q, ecnt_d;
  logic             dat_oe_q, dat_oe_d;
  logic             ack_q, ack_d;
  logic             rdy_q;
  logic             c_s1_q, c_s2_q, c_prev_q, d_s1_q, d_s2_q;
  logic             fall, timed, tmo_hit;

  assign fall    = c_prev_q & ~c_s2_q;
  assign timed   = (state_q != S_IDLE) && (state_q != S_INHIBIT);
  assign tmo_hit = timed && (cnt_q == TMO_LIM);

  assign tx_ready   = rdy_q && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign ps2_clk_oe = (state_q == S_INHIBIT);
  // A timeout drops the data line in the same cycle the error is reported.
  assign ps2_dat_oe = dat_oe_q & ~tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      ecnt_q   <= '0;
      dat_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      c_s1_q   <= 1'b1;
      c_s2_q   <= 1'b1;
      c_prev_q <= 1'b1;
      d_s1_q   <= 1'b1;
      d_s2_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      dat_oe_q <= dat_oe_d;
      ack_q    <= ack_d;
      rdy_q    <= 1'b1;
      c_s1_q   <= ps2_clk_in;
      c_s2_q   <= c_s1_q;
      c_prev_q <= c_s2_q;
      d_s1_q   <= ps2_dat_in;
      d_s2_q   <= d_s1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    dat_oe_d = dat_oe_q;
    ack_d    = ack_q;
    tx_done  = 1'b0;
    tx_err   = 1'b0;

    if (timed) begin
      cnt_d = (cnt_q == TMO_LIM) ? cnt_q : cnt_q + 1'b1;
    end

    if (tmo_hit) begin
      tx_err   = 1'b1;
      dat_oe_d = 1'b0;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          dat_oe_d = 1'b0;
          if (tx_valid && rdy_q) begin
            data_d  = tx_data;
            par_d   = ~^tx_data;
            cnt_d   = '0;
            ecnt_d  = '0;
            state_d = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q >= INH_LAST) begin
            cnt_d    = '0;
            dat_oe_d = 1'b1;
            state_d  = S_RTS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RTS: state_d = S_SHIFT;
        S_SHIFT: begin
          if (fall) begin
            ecnt_d = ecnt_q + 4'd1;
            if (ecnt_q < 4'd8) begin
              dat_oe_d = ~data_q[ecnt_q[2:0]];
            end else if (ecnt_q == 4'd8) begin
              dat_oe_d = ~par_q;
            end else begin
              dat_oe_d = 1'b0;
              state_d  = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (fall) begin
            ecnt_d  = ecnt_q + 4'd1;
            ack_d   = d_s2_q;
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          if (ack_q) begin
            tx_err  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (c_s2_q && d_s2_q) begin
            tx_done = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 line model with a device that clocks,
// captures the frame and acks; a scoreboard checks each done/err pulse.
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TMO = 1500;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;
  logic [10:0] dev_frame = '0;

  int nvec = 0;
  int nfail = 0;
  int ndone = 0;
  int nerr = 0;

  typedef struct {
    bit          is_err;
    bit          chk_frame;
    logic [10:0] frame;
  } exp_t;
  exp_t sbq[$];

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push(bit is_err, bit chk, logic [10:0] fr);
    exp_t e;
    e.is_err = is_err;
    e.chk_frame = chk;
    e.frame = fr;
    sbq.push_back(e);
  endfunction

  // Monitor: pops an expectation for every pulse the DUT presents.
  always @(negedge clk) begin
    if (tx_done || tx_err) begin
      exp_t e;
      check("done_err_exclusive", {31'd0, tx_done & tx_err}, 0);
      if (tx_done) ndone++;
      if (tx_err) nerr++;
      if (sbq.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", tx_done, tx_err);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind_err", {31'd0, tx_err}, {31'd0, e.is_err});
        if (e.chk_frame) check("frame", {21'd0, dev_frame}, {21'd0, e.frame});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Device: waits for request-to-send, gives n_edges clock pulses, samples on rising edges.
  task automatic device(input int n_edges, input bit ack);
    int w = 0;
    dev_frame = '0;
    @(negedge clk);
    while (!(ps2_clk_line && !ps2_dat_line) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("dev_saw_rts", {31'd0, w < 3000}, 1);
    repeat (10) @(negedge clk);
    for (int n = 1; n <= n_edges; n++) begin
      if (n == 11 && ack) dev_dat_low = 1'b1;
      repeat (H) @(negedge clk);
      if (n == 1) dev_frame[0] = ps2_dat_line;
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      if (n <= 10) dev_frame[n] = ps2_dat_line;
    end
    repeat (H) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!tx_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", {31'd0, tx_ready}, 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'h5A;
  endtask

  task automatic measure_inhibit();
    int n = 0;
    while (ps2_clk_oe && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", n, INH);
    check("rts_dat_oe", {31'd0, ps2_dat_oe}, 1);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("back_to_idle", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, tx_ready, tx_done, tx_err}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, tx_ready}, 1);
    check("idle_busy", {31'd0, busy}, 0);

    // 8'hED with ack: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    push(1'b0, 1'b1, 11'h7DA);
    send(8'hED);
    measure_inhibit();
    device(11, 1'b1);
    wait_idle();

    // Clock falls in IDLE are ignored; then 8'h07: bits 1,1,1,0,0,0,0,0, parity 0
    for (int i = 0; i < 3; i++) begin
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    check("idle_falls_no_busy", {31'd0, busy}, 0);
    push(1'b0, 1'b1, 11'h40E);
    send(8'h07);
    measure_inhibit();
    device(11, 1'b1);
    wait_idle();

    // No ack at edge 11: tx_err, ready the next cycle
    push(1'b1, 1'b1, 11'h7DA);
    send(8'hED);
    measure_inhibit();
    fork
      device(11, 1'b0);
      begin
        int w = 0;
        while (!tx_err && w < 3000) begin
          @(negedge clk);
          w++;
        end
        check("noack_err_seen", {31'd0, tx_err}, 1);
        @(negedge clk);
        check("noack_ready_next", {31'd0, tx_ready}, 1);
      end
    join
    wait_idle();

    // Device never clocks: tx_err exactly TMO cycles after clock release
    push(1'b1, 1'b0, 11'h000);
    send(8'h07);
    measure_inhibit();
    begin
      int n = 0;
      while (!tx_err && n < TMO + 50) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", n, TMO);
      check("timeout_oe_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    end
    wait_idle();

    // tx_valid with 8'hF4 during SHIFT of 8'hED is ignored
    push(1'b0, 1'b1, 11'h7DA);
    send(8'hED);
    measure_inhibit();
    fork
      device(11, 1'b1);
      begin
        repeat (5 * H) @(negedge clk);
        check("busy_ready_low", {31'd0, tx_ready}, 0);
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_idle();

    // Reset after edge 5 of 8'hED: bit 4 is 0, so data is driven low
    send(8'hED);
    measure_inhibit();
    device(5, 1'b1);
    check("pre_reset_dat_oe", {30'd0, busy, ps2_dat_oe}, 3);
    #2 reset = 1'b0;
    #1 check("reset_release_lines", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, tx_ready, tx_done, tx_err}, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", {31'd0, tx_ready}, 1);

    // 8'hF4 after reset: bits 0,0,1,0,1,1,1,1, parity 0
    push(1'b0, 1'b1, 11'h5E8);
    send(8'hF4);
    measure_inhibit();
    device(11, 1'b1);
    wait_idle();

    check("total_done", ndone, 4);
    check("total_err", nerr, 2);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
